// File: rtl/sd_spi_fifo_port_pkg.sv
// Shared constants for the buffered SD-card SPI port: register map, STATUS layout, line idle levels.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_CS     = 3'd1,
    REG_CLICK  = 3'd2,
    REG_STATUS = 3'd3,
    REG_DIV    = 3'd4,
    REG_FILL   = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_off_e;

  typedef enum logic {
    SH_IDLE = 1'b0,
    SH_XFER = 1'b1
  } sh_state_e;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_SH_BUSY  = 4;
  localparam int ST_OVF      = 5;
  localparam int ST_FILL     = 6;

  localparam logic       SPI_MOSI_IDLE = 1'b1;
  localparam logic       SPI_SCK_IDLE  = 1'b0;
  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sd_spi_fifo_port_if.sv
// CPU I/O bus slice seen by the SD SPI port: strobed address/data in, one-cycle-latency read data out.
interface sd_spi_fifo_port_if;
  logic [19:0] iAddr;
  logic        iWr;
  logic        iRd;
  logic [7:0]  iData;
  logic [7:0]  oData;
  logic        oSel;

  modport master (output iAddr, iWr, iRd, iData, input oData, oSel);
  modport slave  (input iAddr, iWr, iRd, iData, output oData, oSel);
endinterface

// File: rtl/sd_spi_shifter.sv
// Mode-0 SPI byte engine, MSB first; 16*(DIV+1) clocks per byte after iStart, oDone pulses as busy drops.
// iStart is only honoured while idle; the caller must hold off during the done cycle.
module sd_spi_shifter
  import sd_spi_pkg::*;
(
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iStart,
  input  logic [7:0] iTx,
  input  logic [7:0] iDiv,
  input  logic       iMiso,
  output logic       oMosi,
  output logic       oSck,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oRx
);

  sh_state_e  state_q, state_d;
  logic       done_q, done_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic [7:0] div_q, div_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] half_q, half_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= SH_IDLE;
      done_q  <= 1'b0;
      sck_q   <= SPI_SCK_IDLE;
      mosi_q  <= SPI_MOSI_IDLE;
      div_q   <= 8'd0;
      cnt_q   <= 8'd0;
      half_q  <= 4'd0;
      tx_sh_q <= 8'd0;
      rx_sh_q <= 8'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
    end
  end

  // Even half-periods end in a rising edge (sample), odd ones in a falling edge (shift out).
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    case (state_q)
      SH_IDLE: begin
        if (iStart) begin
          state_d = SH_XFER;
          div_d   = iDiv;
          cnt_d   = 8'd0;
          half_d  = 4'd0;
          sck_d   = SPI_SCK_IDLE;
          tx_sh_d = iTx;
          mosi_d  = iTx[7];
        end
      end
      SH_XFER: begin
        if (cnt_q == div_q) begin
          cnt_d  = 8'd0;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sck_d   = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], iMiso};
          end else begin
            sck_d   = 1'b0;
            tx_sh_d = {tx_sh_q[6:0], 1'b1};
            mosi_d  = tx_sh_q[6];
            if (half_q == 4'd15) begin
              state_d = SH_IDLE;
              done_d  = 1'b1;
              mosi_d  = SPI_MOSI_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = SH_IDLE;
    endcase
  end

  assign oMosi = mosi_q;
  assign oSck  = sck_q;
  assign oBusy = (state_q == SH_XFER);
  assign oDone = done_q;
  assign oRx   = rx_sh_q;

endmodule

// File: rtl/sd_spi_fifo_port.sv
// I/O-mapped SD SPI master with TX/RX FIFOs, SCK divider, chip selects and 0xFF fill bursts; reads 1-cycle latency.
// Full TX drops writes (sticky OVF); bytes are never launched while RX is full, so RX cannot overflow.
module sd_spi_fifo_port
  import sd_spi_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = 12'h0B8,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          NUM_CS      = 2,
  parameter logic [7:0]  DEFAULT_DIV = 8'd15
) (
  input  logic               iClk,
  input  logic               iRstN,
  sd_spi_fifo_port_if.slave  bus,
  input  logic               iSdMiso,
  output logic               oSdMosi,
  output logic               oSdSck,
  output logic [NUM_CS-1:0]  oSdCs,
  output logic               oBusy,
  output logic               oClick
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [AW:0]       tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]       rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              click_q, click_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        div_q, div_d;
  logic [7:0]        fill_cnt_q, fill_cnt_d;
  logic [7:0]        odata_q, odata_d;
  logic              osel_q, osel_d;

  logic       addr_hit, wr_hit, rd_hit, unused_addr_hi;
  reg_off_e   off;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       sh_busy, sh_done, sh_idle;
  logic [7:0] sh_rx, sh_tx;
  logic       launch, tx_pop, tx_push, rx_push, rx_pop, fill_dec;
  logic [7:0] rdata, status;

  assign unused_addr_hi = ^bus.iAddr[19:12];
  assign addr_hit = (bus.iAddr[11:3] == BASE_ADDR[11:3]);
  assign off      = reg_off_e'(bus.iAddr[2:0]);
  assign wr_hit   = bus.iWr && addr_hit;
  assign rd_hit   = bus.iRd && addr_hit;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  // The done cycle is not idle, so a new byte starts at the earliest one cycle after the RX push.
  assign sh_idle  = !sh_busy && !sh_done;
  assign launch   = sh_idle && !rx_full && (!tx_empty || (fill_cnt_q != 8'd0));
  assign tx_pop   = launch && !tx_empty;
  assign fill_dec = launch && tx_empty;
  assign tx_push  = wr_hit && (off == REG_DATA) && (!tx_full || tx_pop);
  assign rx_push  = sh_done;
  assign rx_pop   = rd_hit && (off == REG_DATA) && !rx_empty;
  assign sh_tx    = tx_empty ? SPI_FILL_BYTE : tx_mem[tx_rp_q[AW-1:0]];

  always_ff @(posedge iClk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= bus.iData;
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= sh_rx;
  end

  always_comb begin
    status              = 8'd0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_SH_BUSY]  = sh_busy;
    status[ST_OVF]      = ovf_q;
    status[ST_FILL]     = (fill_cnt_q != 8'd0);
  end

  always_comb begin
    rdata = 8'd0;
    case (off)
      REG_DATA:   rdata = rx_empty ? 8'hFF : rx_mem[rx_rp_q[AW-1:0]];
      REG_CS:     rdata[NUM_CS-1:0] = cs_q;
      REG_CLICK:  rdata[0] = click_q;
      REG_STATUS: rdata = status;
      REG_DIV:    rdata = div_q;
      REG_FILL:   rdata = fill_cnt_q;
      default:    rdata = 8'd0;
    endcase
  end

  always_comb begin
    tx_wp_d    = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d    = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
    rx_wp_d    = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d    = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;
    cs_d       = cs_q;
    click_d    = click_q;
    div_d      = div_q;
    fill_cnt_d = fill_dec ? fill_cnt_q - 8'd1 : fill_cnt_q;
    ovf_d      = ovf_q;
    if (wr_hit) begin
      case (off)
        REG_CS:     cs_d = bus.iData[NUM_CS-1:0];
        REG_CLICK:  click_d = !click_q;
        REG_STATUS: if (bus.iData[ST_OVF]) ovf_d = 1'b0;
        REG_DIV:    div_d = bus.iData;
        REG_FILL:   fill_cnt_d = bus.iData;
        default:    ;
      endcase
    end
    // A dropped DATA write outranks a same-cycle OVF clear.
    if (wr_hit && (off == REG_DATA) && !tx_push) ovf_d = 1'b1;
    osel_d  = rd_hit && (off != REG_RSVD6) && (off != REG_RSVD7);
    odata_d = osel_d ? rdata : odata_q;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      cs_q       <= '1;
      click_q    <= 1'b0;
      ovf_q      <= 1'b0;
      div_q      <= DEFAULT_DIV;
      fill_cnt_q <= 8'd0;
      odata_q    <= 8'd0;
      osel_q     <= 1'b0;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      cs_q       <= cs_d;
      click_q    <= click_d;
      ovf_q      <= ovf_d;
      div_q      <= div_d;
      fill_cnt_q <= fill_cnt_d;
      odata_q    <= odata_d;
      osel_q     <= osel_d;
    end
  end

  sd_spi_shifter u_shifter (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iStart (launch),
    .iTx    (sh_tx),
    .iDiv   (div_q),
    .iMiso  (iSdMiso),
    .oMosi  (oSdMosi),
    .oSck   (oSdSck),
    .oBusy  (sh_busy),
    .oDone  (sh_done),
    .oRx    (sh_rx)
  );

  assign bus.oData = odata_q;
  assign bus.oSel  = osel_q;
  assign oSdCs     = cs_q;
  assign oClick    = click_q;
  assign oBusy     = !tx_empty || (fill_cnt_q != 8'd0) || sh_busy;

endmodule

// File: tb/tb_sd_spi_fifo_port.sv
// Scoreboarded bench for sd_spi_fifo_port: reads and MOSI bytes are queued at issue and checked by monitors.
module tb_sd_spi_fifo_port;
  import sd_spi_pkg::*;

  localparam logic [11:0] BASE = 12'h0B8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_spi_fifo_port_if bus ();
  logic       miso, mosi, sck, busy, click;
  logic [1:0] cs;

  sd_spi_fifo_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(16), .NUM_CS(2), .DEFAULT_DIV(8'd15)) u_dut (
    .iClk(clk), .iRstN(rst_n), .bus(bus), .iSdMiso(miso), .oSdMosi(mosi),
    .oSdSck(sck), .oSdCs(cs), .oBusy(busy), .oClick(click)
  );

  typedef struct { logic [2:0] off; logic [7:0] val; } rd_exp_t;
  rd_exp_t    exp_rd[$];
  logic [7:0] exp_mosi[$];
  int         checks = 0;
  int         errors = 0;
  int         mosi_cnt = 0;
  logic [2:0] mbit = 3'd0;
  logic [7:0] mosi_sh = 8'd0;
  logic [7:0] miso_byte = 8'hFF;

  assign miso = miso_byte[3'd7 - mbit];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read monitor: every oSel cycle must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.oSel) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %0h expected none", bus.oData);
      end else begin
        rd_exp_t e;
        e = exp_rd.pop_front();
        if (bus.oData !== e.val) begin
          errors++;
          $display("FAIL rd_off%0d got %0h expected %0h", e.off, bus.oData, e.val);
        end
      end
    end
  end

  // SD card model: captures MOSI and advances MISO on each SCK rising edge.
  always @(posedge sck) begin
    mosi_sh = {mosi_sh[6:0], mosi};
    mbit = mbit + 3'd1;
    if (mbit == 3'd0) begin
      mosi_cnt++;
      checks++;
      if (exp_mosi.size() == 0) begin
        errors++;
        $display("FAIL mosi_unexpected got %0h expected none", mosi_sh);
      end else begin
        logic [7:0] e;
        e = exp_mosi.pop_front();
        if (mosi_sh !== e) begin
          errors++;
          $display("FAIL mosi_byte got %0h expected %0h", mosi_sh, e);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    @(posedge clk); #1;
    bus.iAddr = {8'h5A, BASE | {9'd0, off}};
    bus.iData = d;
    bus.iWr   = 1'b1;
    @(posedge clk); #1;
    bus.iWr   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, input logic [7:0] exp);
    rd_exp_t e;
    e.off = off;
    e.val = exp;
    @(posedge clk); #1;
    exp_rd.push_back(e);
    bus.iAddr = {8'h00, BASE | {9'd0, off}};
    bus.iRd   = 1'b1;
    @(posedge clk); #1;
    bus.iRd   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout got busy=1 expected 0", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mbit = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb, nsck, base;
    rd_exp_t e;
    bus.iAddr = '0; bus.iWr = 1'b0; bus.iRd = 1'b0; bus.iData = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", int'(sck), 0);
    chk("rst_mosi", int'(mosi), 1);
    chk("rst_cs", int'(cs), 3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_click", int'(click), 0);
    chk("rst_osel", int'(bus.oSel), 0);
    chk("rst_odata", int'(bus.oData), 0);
    rst_n = 1'b1;

    rd(REG_STATUS, 8'h0A);
    rd(REG_DIV, 8'h0F);
    rd(REG_DATA, 8'hFF);
    rd(REG_FILL, 8'h00);
    @(posedge clk); #1;
    bus.iAddr = {8'h00, BASE | 12'd6}; bus.iRd = 1'b1;
    @(posedge clk); #1;
    bus.iRd = 1'b0;

    wr(REG_CS, 8'hFE);
    chk("cs_write", int'(cs), 2);
    rd(REG_CS, 8'h02);
    wr(REG_CS, 8'hFF);
    wr(REG_CLICK, 8'h00);
    chk("click_1", int'(click), 1);
    rd(REG_CLICK, 8'h01);
    wr(REG_CLICK, 8'hFF);
    chk("click_0", int'(click), 0);

    // Single byte at DIV=0: one cycle TX-pending, then 16 shift clocks.
    wr(REG_DIV, 8'h00);
    miso_byte = 8'h3C;
    exp_mosi.push_back(8'hA5);
    wr(REG_DATA, 8'hA5);
    nb = 0; nsck = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (sck) nsck++;
      if (!busy) break;
    end
    chk("busy_cycles", nb, 17);
    chk("sck_high_cycles", nsck, 8);
    rd(REG_DATA, 8'h3C);
    rd(REG_STATUS, 8'h0A);

    // RX fills after 16 bytes and the 17th stays in TX.
    wr(REG_DIV, 8'h03);
    miso_byte = 8'h81;
    base = mosi_cnt;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_mosi.push_back(8'h10 + 8'(i));
      wr(REG_DATA, 8'h10 + 8'(i));
    end
    for (int n = 0; n < 3000 && mosi_cnt < base + 16; n++) @(negedge clk);
    repeat (300) @(negedge clk);
    chk("rxfull_bytes_sent", mosi_cnt - base, 16);
    rd(REG_STATUS, 8'h04);
    for (int i = 0; i < 16; i++) wr(REG_DATA, 8'h40 + 8'(i));
    rd(REG_STATUS, 8'h25);
    chk("stalled_busy", int'(busy), 1);
    chk("stalled_sck", int'(sck), 0);
    wr(REG_STATUS, 8'h20);
    rd(REG_STATUS, 8'h05);
    do_reset();
    rd(REG_STATUS, 8'h0A);
    rd(REG_DIV, 8'h0F);

    // Fill burst of four 0xFF bytes with MISO held low.
    wr(REG_DIV, 8'h00);
    miso_byte = 8'h00;
    base = mosi_cnt;
    for (int i = 0; i < 4; i++) exp_mosi.push_back(8'hFF);
    wr(REG_FILL, 8'h04);
    wait_idle("fill", 500);
    chk("fill_bytes_sent", mosi_cnt - base, 4);
    rd(REG_FILL, 8'h00);
    for (int i = 0; i < 4; i++) rd(REG_DATA, 8'h00);
    rd(REG_DATA, 8'hFF);
    rd(REG_STATUS, 8'h0A);

    // DATA read landing in the RX push cycle with one entry already queued.
    miso_byte = 8'h11;
    exp_mosi.push_back(8'h22);
    wr(REG_DATA, 8'h22);
    wait_idle("first_byte", 200);
    miso_byte = 8'h33;
    exp_mosi.push_back(8'h44);
    wr(REG_DATA, 8'h44);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    e.off = REG_DATA; e.val = 8'h11;
    exp_rd.push_back(e);
    bus.iAddr = {8'h00, BASE}; bus.iRd = 1'b1;
    @(posedge clk); #1;
    bus.iRd = 1'b0;
    rd(REG_DATA, 8'h33);
    rd(REG_DATA, 8'hFF);

    // Reset in the middle of a byte.
    wr(REG_DIV, 8'h03);
    wr(REG_CS, 8'h00);
    chk("cs_low", int'(cs), 0);
    miso_byte = 8'hFF;
    base = mosi_cnt;
    wr(REG_DATA, 8'h5A);
    for (int n = 0; n < 500 && mbit != 3'd3; n++) @(negedge clk);
    chk("midbyte_reached", int'(mbit), 3);
    rst_n = 1'b0;
    mbit = 3'd0;
    #1;
    chk("midrst_sck", int'(sck), 0);
    chk("midrst_cs", int'(cs), 3);
    chk("midrst_mosi", int'(mosi), 1);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("midrst_no_bytes", mosi_cnt - base, 0);
    rd(REG_STATUS, 8'h0A);
    rd(REG_DATA, 8'hFF);
    rd(REG_CS, 8'h03);

    repeat (5) @(negedge clk);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("mosi_queue_drained", exp_mosi.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
